// File: rtl/steer_en_if.sv
// Load-cell inputs and rider-status outputs between the A2D side and steer_en.
interface steer_en_if;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        en_steer;
  logic        rider_off;

  modport master (
    output lft_ld,
    output rght_ld,
    input  en_steer,
    input  rider_off
  );

  modport slave (
    input  lft_ld,
    input  rght_ld,
    output en_steer,
    output rider_off
  );
endinterface

// File: rtl/steer_en.sv
// Rider-presence and balance qualifier: decides whether a rider is on the
// platform and whether steering may be enabled after a settle period.
module steer_en #(
  parameter bit          fast_sim     = 1'b0,
  parameter logic [11:0] MIN_RIDER_WT = 12'h200,
  parameter logic [11:0] WT_HYST      = 12'h040
) (
  input  logic      clk,
  input  logic      rst_n,
  steer_en_if.slave bus
);

  localparam logic [12:0] WT_HI   = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
  localparam logic [12:0] WT_LO   = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};
  localparam logic [25:0] TMR_MAX = fast_sim ? 26'h0007FFF : 26'h3FFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STEER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic        [25:0] tmr_q, tmr_d;
  logic               en_steer_q, en_steer_d;
  logic               rider_off_q, rider_off_d;

  logic        [12:0] sum;
  logic signed [12:0] sdiff;
  logic        [11:0] diff;
  logic               wt_ok, wt_low, unbal_1_4, unbal_15_16, tmr_full;

  // Weight/balance arithmetic and threshold comparisons, evaluated every cycle
  always_comb begin
    sum   = {1'b0, bus.lft_ld} + {1'b0, bus.rght_ld};
    sdiff = signed'({1'b0, bus.lft_ld}) - signed'({1'b0, bus.rght_ld});
    diff  = sdiff[12] ? (~sdiff[11:0] + 12'd1) : sdiff[11:0];

    wt_ok       = sum > WT_HI;
    wt_low      = sum < WT_LO;
    unbal_1_4   = {1'b0, diff} > {2'b00, sum[12:2]};
    unbal_15_16 = {1'b0, diff} > (sum - {4'b0000, sum[12:4]});
    tmr_full    = tmr_q == TMR_MAX;
  end

  // Next-state, settle-timer and output decode; weight checks outrank balance
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wt_ok) begin
          state_d = ST_WAIT;
          tmr_d   = '0;
        end
      end
      ST_WAIT: begin
        if (wt_low) begin
          state_d = ST_IDLE;
        end else if (unbal_1_4) begin
          tmr_d = '0;
        end else if (tmr_full) begin
          state_d = ST_STEER;
        end else begin
          tmr_d = tmr_q + 26'd1;
        end
      end
      ST_STEER: begin
        if (wt_low) begin
          state_d = ST_IDLE;
        end else if (unbal_15_16) begin
          state_d = ST_WAIT;
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase
    // Outputs are loaded from the next state so they change with the state register
    en_steer_d  = state_d == ST_STEER;
    rider_off_d = state_d == ST_IDLE;
  end

  // State, timer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      en_steer_q  <= 1'b0;
      rider_off_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      en_steer_q  <= en_steer_d;
      rider_off_q <= rider_off_d;
    end
  end

  assign bus.en_steer  = en_steer_q;
  assign bus.rider_off = rider_off_q;

endmodule

// File: doc/steer_en.md
# steer_en

Rider-presence and balance qualifier. It sits directly downstream of the A2D interface and consumes its free-running `lft_ld` and `rght_ld` load-cell readings. It decides whether a rider is on the platform and whether steering may be enabled. Outputs feed the balance controller and the steering mixer.

## Interface
- `fast_sim`, default 0 — when 1, shortens the settle timer to 2^15 cycles for simulation.
- `MIN_RIDER_WT`, default 12'h200 — nominal rider-weight threshold on `lft_ld + rght_ld`.
- `WT_HYST`, default 12'h040 — hysteresis applied around `MIN_RIDER_WT`.
- `clk`  input  1  — system clock (50 MHz).
- `rst_n`  input  1  — reset, asynchronous, active-low; clock is `clk`.
- `lft_ld`  input  12  — left load-cell reading, unsigned, from the A2D interface.
- `rght_ld`  input  12  — right load-cell reading, unsigned, from the A2D interface.
- `en_steer`  output  1  — steering enabled: rider present and balanced for the full settle time.
- `rider_off`  output  1  — no rider detected.

## Operation
- Arithmetic is combinational and evaluated every cycle. The inputs are level data, with no valid strobe.
  - `sum` = `lft_ld + rght_ld`, 13-bit unsigned.
  - `diff` = |`lft_ld` − `rght_ld`|, computed as a 13-bit signed subtraction, then magnitude, giving 12 bits.
- Comparators, all 13-bit unsigned:
  - `wt_ok`: `sum` > `MIN_RIDER_WT` + `WT_HYST` (0x240 at defaults).
  - `wt_low`: `sum` < `MIN_RIDER_WT` − `WT_HYST` (0x1C0 at defaults).
  - `unbal_1_4`: `diff` > `sum[12:2]`.
  - `unbal_15_16`: `diff` > (`sum` − `sum[12:4]`).
- Settle timer: 26-bit counter. `tmr_full` is asserted when count == `TMR_MAX`.
  - `TMR_MAX` = 2^26−1 (about 1.34 s) when `fast_sim`=0.
  - `TMR_MAX` = 2^15−1 when `fast_sim`=1.
- FSM states: IDLE, WAIT, STEER.
  - IDLE: if `wt_ok` → WAIT and clear the timer; otherwise stay in IDLE.
  - WAIT, with priority in this order:
    1. `wt_low` → IDLE.
    2. `unbal_1_4` → clear the timer and stay in WAIT.
    3. `tmr_full` → STEER.
    4. Otherwise increment the timer.
  - STEER, with priority in this order:
    1. `wt_low` → IDLE.
    2. `unbal_15_16` → WAIT and clear the timer.
    3. Otherwise stay in STEER.
- Weight checks take priority over balance checks in every state.
- Sums between 0x1C0 and 0x240 cause no state change; this is the hysteresis band.
- Outputs are flops loaded from the next state on the same edge as the state register, so they are glitch-free.
  - `en_steer` = (state == STEER).
  - `rider_off` = (state == IDLE).
- The timer never wraps. It is only cleared or incremented while in WAIT, and the transition to STEER occurs at `tmr_full`.

## Timing
- Reset: state = IDLE, timer = 0, `en_steer` = 0, `rider_off` = 1.
- Reset asserted mid-operation forces the reset values immediately (asynchronous). Timer progress is lost.
- IDLE→WAIT: `rider_off` falls on the first clock edge at which `wt_ok` is sampled.
- WAIT→STEER latency: timer = 0 in the first WAIT cycle. `en_steer` rises on the edge `TMR_MAX`+1 cycles after WAIT entry (32768 cycles with `fast_sim`=1), provided there is no imbalance or weight loss in between.
- Any `unbal_1_4` cycle in WAIT restarts the full `TMR_MAX`+1 count from the cycle after the imbalance clears.
- STEER→WAIT or STEER→IDLE: `en_steer` falls on the first edge at which the condition is sampled.
- A single-cycle input excursion is enough to cause a transition. Any filtering belongs upstream.

## Test plan
All scenarios use `fast_sim`=1.
- Reset: assert `rst_n`=0 with `lft_ld`=`rght_ld`=0x300. Required: `en_steer`=0 and `rider_off`=1 during reset and after release, until the first edge.
- Mount: drive `lft_ld`=`rght_ld`=0x150 (sum 0x2A0). Required:
  - `rider_off`=0 after 1 edge.
  - `en_steer`=0 at cycle 32767 after WAIT entry.
  - `en_steer`=1 at cycle 32768.
- Imbalance restart: in WAIT, at count 20000, drive `lft_ld`=0x200, `rght_ld`=0x0A0 for 10 cycles (diff 0x160 > 0xA8), then drive 0x150/0x150. Required: `en_steer` rises 32768 cycles after balance is restored.
- Steer drop on imbalance: in STEER, drive `lft_ld`=0x280, `rght_ld`=0x010 (diff 0x270 > 0x267). Required: `en_steer`=0 next edge, `rider_off` stays 0, and a subsequent rebalance needs the full 32768 cycles.
- Hysteresis:
  - In IDLE with sum 0x200 (0x100/0x100): stays IDLE.
  - In STEER with sum 0x200: stays STEER.
  - Sum 0x1B0 (0x100/0x0B0): IDLE next edge, `rider_off`=1, `en_steer`=0.
- Priority and mid-reset:
  - In WAIT, drive sum 0x1B0 with a large diff. Required: IDLE, not a timer clear.
  - Pulse `rst_n` low at WAIT count 30000 and hold 0x150/0x150. Required: re-enter WAIT, then `en_steer` after a full 32768 cycles.
